// File: rtl/sync_fifo_ext_if.sv
// Handshake/data bundle for sync_fifo_ext: the producer/consumer side drives the
// master modport, and the FIFO itself takes the slave modport.
interface sync_fifo_ext_if #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 8
) ();
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] din;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] dout;
   logic                  rd_valid;
   logic [CW-1:0]         count;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  clr_err;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, din, rd_en, clr_err,
      input  dout, rd_valid, count, full, empty, almost_full, almost_empty,
             overflow, underflow
   );

   modport slave (
      input  wr_en, din, rd_en, clr_err,
      output dout, rd_valid, count, full, empty, almost_full, almost_empty,
             overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_ext.sv
// Single-clock elastic FIFO with occupancy count, almost flags, optional
// first-word-fall-through output and sticky overflow/underflow flags.
module sync_fifo_ext #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int FWFT       = 0,
   parameter int AF_THRESH  = FIFO_DEPTH - 1,
   parameter int AE_THRESH  = 1
) (
   input logic            clk,
   input logic            rst,
   sync_fifo_ext_if.slave fifo
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  rd_valid_q;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic                  full, empty;
   logic                  rd_acc, wr_acc;
   logic [DATA_WIDTH-1:0] head;

   // Pointer MSBs differ only when the writer has lapped the reader.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign rd_acc = fifo.rd_en & ~empty;
   assign wr_acc = fifo.wr_en & (~full | fifo.rd_en);
   assign head   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (wr_acc)
         wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc)
         rd_ptr_d = rd_ptr_q + PW'(1);
      if (wr_acc && !rd_acc)
         count_d = count_q + PW'(1);
      else if (rd_acc && !wr_acc)
         count_d = count_q - PW'(1);
      // A fresh error event outranks a simultaneous clear.
      if (fifo.clr_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (fifo.wr_en && full && !fifo.rd_en)
         overflow_d = 1'b1;
      if (fifo.rd_en && empty)
         underflow_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         dout_q      <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rd_valid_q  <= rd_acc;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         if (rd_acc)
            dout_q <= head;
      end
   end

   // Storage is deliberately left unreset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem_q[wr_ptr_q[AW-1:0]] <= fifo.din;
   end

   // In FWFT mode dout_q doubles as the last popped word shown while empty.
   assign fifo.dout         = (FWFT != 0 && !empty) ? head : dout_q;
   assign fifo.rd_valid     = (FWFT != 0) ? ~empty : rd_valid_q;
   assign fifo.count        = count_q;
   assign fifo.full         = full;
   assign fifo.empty        = empty;
   assign fifo.almost_full  = (count_q >= PW'(AF_THRESH));
   assign fifo.almost_empty = (count_q <= PW'(AE_THRESH));
   assign fifo.overflow     = overflow_q;
   assign fifo.underflow    = underflow_q;
endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
Parametrised synchronous FIFO, next generation of the team's single-clock FIFO. Adds:
- occupancy count
- programmable almost-full / almost-empty flags
- first-word-fall-through (FWFT) or registered-read mode
- same-cycle read+write when full
- sticky overflow/underflow error flags

Used as the generic elastic buffer between streaming datapath stages in one clock domain.

Parameters:
DATA_WIDTH, 16, data word width in bits (>=1)
FIFO_DEPTH, 8, number of entries; power of two, >=2
FWFT, 0, 0 = registered read (data one cycle after accepted read); 1 = head word visible on dout while !empty
AF_THRESH, FIFO_DEPTH-1, almost_full asserted when count >= AF_THRESH (1..FIFO_DEPTH)
AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..FIFO_DEPTH-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
wr_en  in  1  write request
din  in  DATA_WIDTH  write data
rd_en  in  1  read request
dout  out  DATA_WIDTH  read data
rd_valid  out  1  FWFT=0: pulses one cycle after an accepted read; FWFT=1: equals !empty
count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
full  out  1  count == FIFO_DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
clr_err  in  1  synchronous clear of overflow/underflow
overflow  out  1  sticky: write rejected
underflow  out  1  sticky: read rejected

Behaviour:
- Reset (rst low, async):
  - pointers = 0, count = 0, dout = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset.
- Pointers are log2(DEPTH)+1 bits wide. The MSB distinguishes full from empty; the lower bits index memory and wrap naturally.
- Read and write acceptance:
  - rd_acc = rd_en & !empty.
  - wr_acc = wr_en & (!full | rd_en). Writing when full is allowed only alongside a same-cycle read, which frees the slot.
- Empty with rd_en & wr_en both high: the write is accepted, the read is rejected, and underflow is set.
- Count update:
  - +1 on wr_acc & !rd_acc
  - -1 on rd_acc & !wr_acc
  - unchanged otherwise
  - Never exceeds FIFO_DEPTH and never goes below 0.
- Flags (full, empty, almost_*) are registered or derived from registered count/pointers only. They update on the same edge as count, with no combinational path from wr_en/rd_en.
- FWFT=0 read path:
  - On rd_acc, dout <= mem[rd_idx] and rd_valid <= 1 on the next edge. Otherwise rd_valid <= 0 and dout holds.
  - Read latency: 1 cycle.
- FWFT=1 read path:
  - dout = mem[rd_idx] whenever !empty. When empty, dout holds the last value, or 0 after reset.
  - rd_en acts as pop/acknowledge.
  - First-write-to-dout latency: 1 cycle (word visible the cycle after the write edge).
- Same-index read/write when full with rd_en & wr_en: the read returns the old head word and the new word is stored in the freed slot.
- Error flags:
  - overflow <= 1 on wr_en & full & !rd_en.
  - underflow <= 1 on rd_en & empty.
  - Both clear only on clr_err or reset. If clr_err coincides with a new error event, the set wins.
- Rejected operations change no pointer, count or data.
- Reset asserted mid-burst: all state returns to reset values immediately. After release, the FIFO is empty and behaves as fresh.

Test Plan:
- DEPTH=8, FWFT=0: reset, write 0x0001..0x0008 -> full=1, count=8, almost_full=1 from count 7. Then 8 reads -> dout 0x0001..0x0008, each one cycle after its rd_en, with rd_valid pulses. Ends empty=1, count=0.
- Full, write 0xAAAA with rd_en=0 -> write rejected, overflow=1 (sticky), count stays 8. Then clr_err -> overflow=0.
- Full, rd_en=1 & wr_en=1 with din=0xBEEF -> head 0x0001 read, count stays 8, full stays 1. 0xBEEF emerges as the eighth subsequent read.
- Empty, rd_en=1 & wr_en=1 with din=0x1234 -> underflow=1, count=1. FWFT=1 build: dout=0x1234 and rd_valid=1 the following cycle.
- Wrap-around: 20 interleaved write/read pairs through DEPTH=8 with incrementing data -> output order matches input order exactly, count never exceeds 8.
- Reset asserted with count=5 -> same cycle: count=0, empty=1, rd_valid=0, errors cleared. After release: write 0x0042, read -> dout=0x0042.
